exp_req_ctrl: RTL and testbench

Exception-request controller on the requesting side of the CP0 exception interface. It edge-detects three external request lines and latches them as pending, masks and prioritises them, and raises exactly one of ExpSrc0/1/2 toward CP0. It holds that request until CP0 accepts it (HasExp), then waits for the handler to return (IsEret) before dispatching the next one. It sits between the interrupt/fault sources and CP0 in the single-cycle MIPS datapath.

---
 rtl/exp_req_if.sv | 27 ++
 rtl/exp_req_ctrl.sv | 133 +++++++++++++
 tb/tb_exp_req_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/exp_req_if.sv
`default_nettype none
// ============================================================================
// Module      : exp_req_if
// Description : CP0 exception request/acknowledge handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface exp_req_if;
    logic ExpSrc0;
    logic ExpSrc1;
    logic ExpSrc2;
    logic HasExp;
    logic ExpBlock;
    logic IsEret;

    // Requesting side: raises one ExpSrc line, observes CP0 status.
    modport master (
        output ExpSrc0, ExpSrc1, ExpSrc2,
        input  HasExp, ExpBlock, IsEret
    );

    // CP0 side.
    modport slave (
        input  ExpSrc0, ExpSrc1, ExpSrc2,
        output HasExp, ExpBlock, IsEret
    );
endinterface
`default_nettype wire

// File: rtl/exp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exp_req_ctrl
// Description : Edge-detects, masks and prioritises three exception request
//               lines and issues one registered ExpSrc request at a time to CP0.
// Revision    : 1.0 - initial release
// ============================================================================
module exp_req_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [2:0] irq_in,
    input  wire logic       mask_we,
    input  wire logic [2:0] mask_din,
    input  wire logic       err_clr,
    exp_req_if.master       cp0,
    output logic      [2:0] pending,
    output logic      [2:0] mask,
    output logic            busy,
    output logic            timeout_err
);

    localparam logic [7:0] C_CNT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] C_CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_ERET = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_irq_q;
    logic       r_primed;
    logic [2:0] r_pending;
    logic [2:0] r_mask;
    logic [2:0] r_cur;
    logic [2:0] w_cur_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [2:0] r_expsrc;
    logic [2:0] w_expsrc_nxt;
    logic       r_timeout_err;

    logic [2:0] w_rise;
    logic [2:0] w_cand;
    logic [2:0] w_pick;
    logic [2:0] w_acc;
    logic       w_to_set;

    // No edge is reported on the first cycle after reset, so a line that was
    // already high across reset must fall and rise again to be seen.
    assign w_rise = irq_in & ~r_irq_q & {3{r_primed}};
    assign w_cand = r_pending & r_mask;

    always_comb begin
        w_pick = 3'b000;
        if (w_cand[0])      w_pick = 3'b001;
        else if (w_cand[1]) w_pick = 3'b010;
        else if (w_cand[2]) w_pick = 3'b100;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_cnt_nxt   = r_cnt;
        w_acc       = 3'b000;
        w_to_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((w_cand != 3'b000) && !cp0.ExpBlock) begin
                    w_state_nxt = S_REQ;
                    w_cur_nxt   = w_pick;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_REQ: begin
                if (cp0.HasExp) begin
                    w_acc       = r_cur;
                    w_state_nxt = S_WAIT_ERET;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != C_CNT_MAX) begin
                    w_cnt_nxt   = r_cnt + 8'd1;
                end
            end
            S_WAIT_ERET: begin
                if (cp0.IsEret) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_expsrc_nxt = (w_state_nxt == S_REQ) ? w_cur_nxt : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_irq_q       <= 3'b000;
            r_primed      <= 1'b0;
            r_pending     <= 3'b000;
            r_mask        <= 3'b111;
            r_cur         <= 3'b000;
            r_cnt         <= 8'd0;
            r_expsrc      <= 3'b000;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_irq_q       <= irq_in;
            r_primed      <= 1'b1;
            r_pending     <= (r_pending & ~w_acc) | w_rise;
            if (mask_we) r_mask <= mask_din;
            r_cur         <= w_cur_nxt;
            r_cnt         <= w_cnt_nxt;
            r_expsrc      <= w_expsrc_nxt;
            r_timeout_err <= w_to_set | (r_timeout_err & ~err_clr);
        end
    end

    assign cp0.ExpSrc0  = r_expsrc[0];
    assign cp0.ExpSrc1  = r_expsrc[1];
    assign cp0.ExpSrc2  = r_expsrc[2];
    assign pending      = r_pending;
    assign mask         = r_mask;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_exp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exp_req_ctrl
// Description : Directed self-checking bench for exp_req_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_req_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] irq_in = 3'b000;
    logic       mask_we = 1'b0;
    logic [2:0] mask_din = 3'b000;
    logic       err_clr = 1'b0;
    logic [2:0] pending;
    logic [2:0] mask;
    logic       busy;
    logic       timeout_err;

    int n_chk = 0;
    int n_err = 0;

    exp_req_if bus ();

    exp_req_ctrl #(.ACK_TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_din    (mask_din),
        .err_clr     (err_clr),
        .cp0         (bus.master),
        .pending     (pending),
        .mask        (mask),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    wire [7:0] v_exp  = {5'b0, bus.ExpSrc2, bus.ExpSrc1, bus.ExpSrc0};
    wire [7:0] v_pend = {5'b0, pending};
    wire [7:0] v_mask = {5'b0, mask};
    wire [7:0] v_busy = {7'b0, busy};
    wire [7:0] v_terr = {7'b0, timeout_err};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept the current request and return from the handler.
    task automatic ack_and_eret();
        bus.HasExp = 1'b1;
        tick();
        bus.HasExp = 1'b0;
        bus.IsEret = 1'b1;
        tick();
        bus.IsEret = 1'b0;
    endtask

    initial begin
        bus.HasExp   = 1'b0;
        bus.ExpBlock = 1'b0;
        bus.IsEret   = 1'b0;

        // Reset state
        #12;
        chk("rst_exp",  v_exp,  8'h00);
        chk("rst_pend", v_pend, 8'h00);
        chk("rst_mask", v_mask, 8'h07);
        chk("rst_busy", v_busy, 8'h00);
        chk("rst_terr", v_terr, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        // Single request on bit 1, two-edge latency, held until HasExp
        irq_in = 3'b010;
        tick();
        chk("t1_pend_set", v_pend, 8'h02);
        chk("t1_exp_lat1", v_exp,  8'h00);
        tick();
        chk("t1_exp_lat2", v_exp,  8'h02);
        chk("t1_busy",     v_busy, 8'h01);
        tick(2);
        chk("t1_exp_hold", v_exp,  8'h02);
        bus.HasExp = 1'b1;
        tick();
        bus.HasExp = 1'b0;
        chk("t1_exp_acc",  v_exp,  8'h00);
        chk("t1_pend_clr", v_pend, 8'h00);
        tick(2);
        chk("t1_busy_wait", v_busy, 8'h01);
        bus.IsEret = 1'b1;
        tick();
        bus.IsEret = 1'b0;
        chk("t1_busy_idle", v_busy, 8'h00);
        tick(2);
        chk("t1_held_noretrig", v_exp, 8'h00);
        chk("t1_held_nopend",   v_pend, 8'h00);
        irq_in = 3'b000;
        tick();

        // Simultaneous rise on all three: serviced 0, 1, 2
        irq_in = 3'b111;
        tick();
        irq_in = 3'b000;
        chk("t2_pend", v_pend, 8'h07);
        tick();
        chk("t2_exp0", v_exp, 8'h01);
        ack_and_eret();
        chk("t2_pend_a", v_pend, 8'h06);
        tick();
        chk("t2_exp1", v_exp, 8'h02);
        ack_and_eret();
        chk("t2_pend_b", v_pend, 8'h04);
        tick();
        chk("t2_exp2", v_exp, 8'h04);
        ack_and_eret();
        chk("t2_pend_c", v_pend, 8'h00);
        chk("t2_idle",   v_busy, 8'h00);

        // Masked request latches but waits for unmask
        mask_we = 1'b1; mask_din = 3'b110;
        tick();
        mask_we = 1'b0;
        chk("t3_mask", v_mask, 8'h06);
        irq_in = 3'b001;
        tick();
        irq_in = 3'b000;
        chk("t3_pend", v_pend, 8'h01);
        tick(2);
        chk("t3_exp_masked", v_exp, 8'h00);
        mask_we = 1'b1; mask_din = 3'b111;
        tick();
        mask_we = 1'b0;
        chk("t3_old_mask_used", v_exp, 8'h00);
        tick();
        chk("t3_exp0", v_exp, 8'h01);
        ack_and_eret();

        // ExpBlock holds off dispatch in IDLE, ignored in REQ
        bus.ExpBlock = 1'b1;
        irq_in = 3'b100;
        tick();
        irq_in = 3'b000;
        chk("t4_pend", v_pend, 8'h04);
        tick(2);
        chk("t4_blocked", v_exp,  8'h00);
        chk("t4_idle",    v_busy, 8'h00);
        bus.ExpBlock = 1'b0;
        tick();
        chk("t4_exp2", v_exp, 8'h04);
        bus.ExpBlock = 1'b1;
        tick(2);
        chk("t4_exp2_held", v_exp, 8'h04);
        ack_and_eret();
        bus.ExpBlock = 1'b0;

        // Timeout after 15 cycles in REQ, then retry
        irq_in = 3'b001;
        tick();
        irq_in = 3'b000;
        tick();
        chk("t5_exp0", v_exp, 8'h01);
        tick(14);
        chk("t5_exp0_e14", v_exp,  8'h01);
        chk("t5_terr_e14", v_terr, 8'h00);
        tick();
        chk("t5_exp_drop", v_exp,  8'h00);
        chk("t5_terr",     v_terr, 8'h01);
        chk("t5_pend",     v_pend, 8'h01);
        tick();
        chk("t5_retry", v_exp, 8'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_terr_clr", v_terr, 8'h00);
        ack_and_eret();

        // Asynchronous reset mid-REQ, held line does not re-trigger
        mask_we = 1'b1; mask_din = 3'b011;
        tick();
        mask_we = 1'b0;
        irq_in = 3'b010;
        tick(2);
        chk("t6_exp1", v_exp, 8'h02);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_exp",  v_exp,  8'h00);
        chk("t6_async_pend", v_pend, 8'h00);
        chk("t6_async_mask", v_mask, 8'h07);
        tick();
        rst = 1'b0;
        tick(3);
        chk("t6_held_pend", v_pend, 8'h00);
        chk("t6_held_exp",  v_exp,  8'h00);
        irq_in = 3'b000;
        tick();
        irq_in = 3'b010;
        tick();
        chk("t6_new_pend", v_pend, 8'h02);
        tick();
        chk("t6_new_exp", v_exp, 8'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
